// File: rtl/bus_pkg.sv
// Shared types and constants for the system bus arbiter and its helpers.
package bus_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam logic [DATA_W-1:0] RESET_RDATA = 8'h00;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} arb_state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } bus_req_t;

  // Timeout counter width; a disabled timeout still gets one bit.
  function automatic int cnt_width(input int t);
    return (t < 1) ? 1 : $clog2(t + 1);
  endfunction
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester after i_last wins,
// wrapping from N-1 back to 0; i_last itself has lowest priority.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);
  int            w_sum;
  logic [IW-1:0] w_cand;

  // Scan farthest to nearest so the nearest requesting index overwrites.
  always_comb begin
    o_gnt  = '0;
    o_idx  = '0;
    o_any  = 1'b0;
    w_sum  = 0;
    w_cand = '0;
    for (int off = N; off >= 1; off--) begin
      w_sum = int'(i_last) + off;
      if (w_sum >= N) w_sum = w_sum - N;
      w_cand = IW'(w_sum);
      if (i_req[w_cand]) begin
        o_gnt         = '0;
        o_gnt[w_cand] = 1'b1;
        o_idx         = w_cand;
        o_any         = 1'b1;
      end
    end
  end
endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner of the 16-bit address / 8-bit data system bus.
// One transaction at a time: IDLE (arbitrate) -> BUSY (wait memory) -> DONE (ack).
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int NUM_REQUESTERS = 2,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                                  clock_i,
  input  logic                                  reset_ni,
  input  logic [NUM_REQUESTERS-1:0]             req_i,
  input  logic [NUM_REQUESTERS-1:0]             we_i,
  input  logic [NUM_REQUESTERS-1:0][ADDR_W-1:0] addr_i,
  input  logic [NUM_REQUESTERS-1:0][DATA_W-1:0] wdata_i,
  output logic [NUM_REQUESTERS-1:0]             ack_o,
  output logic [DATA_W-1:0]                     rdata_o,
  output logic                                  timeout_o,
  output logic [NUM_REQUESTERS-1:0]             grant_o,
  output logic [ADDR_W-1:0]                     address_o,
  output logic [DATA_W-1:0]                     data_o,
  output logic                                  write_o,
  output logic                                  data_valid_o,
  input  logic [DATA_W-1:0]                     data_i,
  input  logic                                  data_valid_i
);
  localparam int            IW       = $clog2(NUM_REQUESTERS);
  localparam int            CW       = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TO_LIM   = CW'(TIMEOUT_CYCLES);
  localparam logic [IW-1:0] LAST_RST = IW'(NUM_REQUESTERS - 1);

  arb_state_e                r_state;
  logic [IW-1:0]             r_last;
  logic [IW-1:0]             r_gidx;
  logic [CW-1:0]             r_cnt;
  logic [NUM_REQUESTERS-1:0] r_grant;
  logic [NUM_REQUESTERS-1:0] r_ack;
  logic                      r_timeout;
  logic [DATA_W-1:0]         r_rdata;
  logic [ADDR_W-1:0]         r_addr;
  logic [DATA_W-1:0]         r_data;
  logic                      r_write;
  logic                      r_dvalid;

  logic [NUM_REQUESTERS-1:0] w_gnt;
  logic [IW-1:0]             w_idx;
  logic                      w_any;
  bus_req_t [NUM_REQUESTERS-1:0] w_reqs;
  bus_req_t                  w_sel;

  for (genvar g = 0; g < NUM_REQUESTERS; g++) begin : g_req
    assign w_reqs[g] = {we_i[g], addr_i[g], wdata_i[g]};
  end

  assign w_sel = w_reqs[w_idx];

  rr_pick #(.N(NUM_REQUESTERS), .IW(IW)) u_pick (
    .i_req  (req_i),
    .i_last (r_last),
    .o_gnt  (w_gnt),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state   <= IDLE;
      r_last    <= LAST_RST;
      r_gidx    <= '0;
      r_cnt     <= '0;
      r_grant   <= '0;
      r_ack     <= '0;
      r_timeout <= 1'b0;
      r_rdata   <= RESET_RDATA;
      r_addr    <= '0;
      r_data    <= '0;
      r_write   <= 1'b0;
      r_dvalid  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_ack     <= '0;
          r_timeout <= 1'b0;
          if (w_any) begin
            r_grant  <= w_gnt;
            r_gidx   <= w_idx;
            r_addr   <= w_sel.addr;
            r_write  <= w_sel.we;
            r_data   <= w_sel.wdata;
            r_dvalid <= 1'b1;
            r_cnt    <= '0;
            r_state  <= BUSY;
          end
        end
        BUSY: begin
          // A response in the limit cycle still wins over the timeout.
          if (data_valid_i) begin
            if (!r_write) r_rdata <= data_i;
            r_dvalid  <= 1'b0;
            r_ack     <= r_grant;
            r_timeout <= 1'b0;
            r_state   <= DONE;
          end else if (TIMEOUT_CYCLES != 0 && r_cnt == TO_LIM) begin
            r_dvalid  <= 1'b0;
            r_ack     <= r_grant;
            r_timeout <= 1'b1;
            r_state   <= DONE;
          end else if (TIMEOUT_CYCLES != 0) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          r_ack     <= '0;
          r_timeout <= 1'b0;
          r_grant   <= '0;
          r_last    <= r_gidx;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ack_o        = r_ack;
  assign rdata_o      = r_rdata;
  assign timeout_o    = r_timeout;
  assign grant_o      = r_grant;
  assign address_o    = r_addr;
  assign data_o       = r_data;
  assign write_o      = r_write;
  assign data_valid_o = r_dvalid;
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with default parameters (2 masters, timeout 15).
module tb_bus_arbiter;
  localparam int N = 2;

  logic                clock_i = 1'b0;
  logic                reset_ni = 1'b0;
  logic [N-1:0]        req_i = '0;
  logic [N-1:0]        we_i = '0;
  logic [N-1:0][15:0]  addr_i = '0;
  logic [N-1:0][7:0]   wdata_i = '0;
  logic [N-1:0]        ack_o;
  logic [7:0]          rdata_o;
  logic                timeout_o;
  logic [N-1:0]        grant_o;
  logic [15:0]         address_o;
  logic [7:0]          data_o;
  logic                write_o;
  logic                data_valid_o;
  logic [7:0]          data_i = '0;
  logic                data_valid_i = 1'b0;

  int errors = 0;
  int checks = 0;
  logic [1:0] exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

  bus_arbiter #(.NUM_REQUESTERS(N), .TIMEOUT_CYCLES(15)) dut (
    .clock_i      (clock_i),
    .reset_ni     (reset_ni),
    .req_i        (req_i),
    .we_i         (we_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .ack_o        (ack_o),
    .rdata_o      (rdata_o),
    .timeout_o    (timeout_o),
    .grant_o      (grant_o),
    .address_o    (address_o),
    .data_o       (data_o),
    .write_o      (write_o),
    .data_valid_o (data_valid_o),
    .data_i       (data_i),
    .data_valid_i (data_valid_i)
  );

  always #5 clock_i = ~clock_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".ack"},     32'(ack_o),        32'h0);
    chk({tag, ".tmo"},     32'(timeout_o),    32'h0);
    chk({tag, ".grant"},   32'(grant_o),      32'h0);
    chk({tag, ".rdata"},   32'(rdata_o),      32'h00);
    chk({tag, ".addr"},    32'(address_o),    32'h0000);
    chk({tag, ".data"},    32'(data_o),       32'h00);
    chk({tag, ".write"},   32'(write_o),      32'h0);
    chk({tag, ".dvalid"},  32'(data_valid_o), 32'h0);
  endtask

  initial begin
    // Reset state
    step();
    chk_reset_vals("rst");
    reset_ni = 1'b1;
    step();

    // Single cpu read, memory answers in the first BUSY cycle
    addr_i[0] = 16'h0200;
    addr_i[1] = 16'hBEEF;
    req_i     = 2'b01;
    step();
    chk("t1.grant",  32'(grant_o),      32'h1);
    chk("t1.dvalid", 32'(data_valid_o), 32'h1);
    chk("t1.addr",   32'(address_o),    32'h0200);
    chk("t1.ack_b",  32'(ack_o),        32'h0);
    data_valid_i = 1'b1;
    data_i       = 8'h5A;
    step();
    chk("t1.ack",    32'(ack_o),        32'h1);
    chk("t1.rdata",  32'(rdata_o),      32'h5A);
    chk("t1.tmo",    32'(timeout_o),    32'h0);
    chk("t1.dv_off", 32'(data_valid_o), 32'h0);
    req_i        = 2'b00;
    data_valid_i = 1'b0;
    step();
    chk("t1.ack_a",  32'(ack_o),        32'h0);
    chk("t1.idle_g", 32'(grant_o),      32'h0);

    // Both masters held, immediate response: 0,1,0,1 with acks 3 cycles apart
    #1 reset_ni = 1'b0;
    #2 reset_ni = 1'b1;
    req_i        = 2'b11;
    we_i         = 2'b00;
    data_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_i = 8'h10 + 8'(i);
      step();
      chk("t2.grant", 32'(grant_o), 32'(exp_g[i]));
      chk("t2.ack_b", 32'(ack_o),   32'h0);
      step();
      chk("t2.ack",   32'(ack_o),   32'(exp_g[i]));
      chk("t2.rdata", 32'(rdata_o), 32'h10 + 32'(i));
      if (i == 3) begin
        req_i        = 2'b00;
        data_valid_i = 1'b0;
      end
      step();
      chk("t2.ack_a", 32'(ack_o),   32'h0);
      chk("t2.idle",  32'(grant_o), 32'h0);
    end

    // Master 1 write, memory delays 4 cycles; inputs changed mid-transaction
    req_i      = 2'b10;
    we_i       = 2'b10;
    addr_i[1]  = 16'h2004;
    wdata_i[1] = 8'hC3;
    for (int b = 1; b <= 5; b++) begin
      step();
      chk("t3.dvalid", 32'(data_valid_o), 32'h1);
      chk("t3.write",  32'(write_o),      32'h1);
      chk("t3.addr",   32'(address_o),    32'h2004);
      chk("t3.data",   32'(data_o),       32'hC3);
      chk("t3.ack_b",  32'(ack_o),        32'h0);
      if (b == 1) begin
        addr_i[1]  = 16'hFFFF;
        wdata_i[1] = 8'h00;
        we_i       = 2'b00;
      end
      if (b == 5) begin
        data_valid_i = 1'b1;
        data_i       = 8'hEE;
      end
    end
    step();
    chk("t3.ack",   32'(ack_o),     32'h2);
    chk("t3.rdata", 32'(rdata_o),   32'h13);
    chk("t3.tmo",   32'(timeout_o), 32'h0);
    req_i        = 2'b00;
    data_valid_i = 1'b0;
    step();

    // No memory response: abort after 16 BUSY cycles, ack at cycle 17
    addr_i[0] = 16'h0300;
    req_i     = 2'b01;
    for (int c = 1; c <= 16; c++) begin
      step();
      chk("t4.ack_b",  32'(ack_o),        32'h0);
      chk("t4.dvalid", 32'(data_valid_o), 32'h1);
    end
    step();
    chk("t4.ack",    32'(ack_o),        32'h1);
    chk("t4.tmo",    32'(timeout_o),    32'h1);
    chk("t4.rdata",  32'(rdata_o),      32'h13);
    chk("t4.dv_off", 32'(data_valid_o), 32'h0);
    req_i = 2'b00;
    step();
    chk("t4.tmo_a",  32'(timeout_o),    32'h0);
    chk("t4.ack_a",  32'(ack_o),        32'h0);

    // Response on the 15th BUSY cycle completes normally
    req_i  = 2'b01;
    data_i = 8'hA5;
    for (int c = 1; c <= 15; c++) begin
      step();
      chk("t4b.ack_b", 32'(ack_o), 32'h0);
      if (c == 15) data_valid_i = 1'b1;
    end
    step();
    chk("t4b.ack",   32'(ack_o),     32'h1);
    chk("t4b.tmo",   32'(timeout_o), 32'h0);
    chk("t4b.rdata", 32'(rdata_o),   32'hA5);
    req_i        = 2'b00;
    data_valid_i = 1'b0;
    step();

    // Reset pulsed mid-BUSY
    req_i      = 2'b10;
    we_i       = 2'b10;
    addr_i[1]  = 16'h1234;
    wdata_i[1] = 8'h55;
    step();
    step();
    chk("t5.grant", 32'(grant_o), 32'h2);
    #2 reset_ni = 1'b0;
    #1;
    chk_reset_vals("t5.async");
    step();
    req_i    = 2'b00;
    we_i     = 2'b00;
    reset_ni = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("t5.no_ack", 32'(ack_o), 32'h0);
    end

    // data_valid_i in IDLE and DONE is ignored
    data_valid_i = 1'b1;
    data_i       = 8'h77;
    step();
    chk("t6.idle_g",  32'(grant_o),      32'h0);
    chk("t6.idle_dv", 32'(data_valid_o), 32'h0);
    chk("t6.idle_rd", 32'(rdata_o),      32'h00);
    req_i  = 2'b11;
    data_i = 8'h3C;
    step();
    chk("t6.grant0",  32'(grant_o),      32'h1);
    step();
    chk("t6.ack",     32'(ack_o),        32'h1);
    chk("t6.rdata",   32'(rdata_o),      32'h3C);
    data_i = 8'h88;
    req_i  = 2'b00;
    step();
    chk("t6.done_rd", 32'(rdata_o),      32'h3C);
    chk("t6.ack_a",   32'(ack_o),        32'h0);
    chk("t6.idle2_g", 32'(grant_o),      32'h0);
    step();
    chk("t6.hold_rd", 32'(rdata_o),      32'h3C);
    chk("t6.hold_dv", 32'(data_valid_o), 32'h0);
    data_valid_i = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Shares the single 16-bit-address / 8-bit-data system bus between several masters: the cpu core, the OAM DMA engine, and debug/loader logic. It accepts one request at a time using round-robin arbitration. It drives the memory side and returns a one-cycle acknowledge with read data to the winning requester. It sits between the masters and the address decoder / memory map, and is the only block that drives the memory-side bus.

## Interface
- NUM_REQUESTERS, default 2: number of masters, range 2..8; index 0 is the cpu.
- TIMEOUT_CYCLES, default 15: BUSY cycles without memory response before abort; 0 disables the timeout.
- clock_i  in  1  system clock; single clock domain.
- reset_ni  in  1  asynchronous, active-low reset.
- req_i  in  NUM_REQUESTERS  per-master request; held high until ack_o for that master.
- we_i  in  NUM_REQUESTERS  per-master write enable (1 = write, 0 = read).
- addr_i  in  NUM_REQUESTERS x 16  per-master address, packed [N-1:0][15:0].
- wdata_i  in  NUM_REQUESTERS x 8  per-master write data.
- ack_o  out  NUM_REQUESTERS  one-hot, one-cycle completion pulse.
- rdata_o  out  8  read data; valid while ack_o is nonzero and held afterwards.
- timeout_o  out  1  pulses with ack_o when the transaction was aborted.
- grant_o  out  NUM_REQUESTERS  one-hot owner during BUSY/DONE; zero in IDLE.
- address_o  out  16  memory address.
- data_o  out  8  memory write data.
- write_o  out  1  memory write strobe qualifier.
- data_valid_o  out  1  memory request valid.
- data_i  in  8  memory read data.
- data_valid_i  in  1  memory response/ack; reads and writes both complete on it.

## Operation
- FSM states are IDLE, BUSY, DONE.
- IDLE:
  - If any req_i bit is high, select a winner by round-robin, starting from the index after last_grant and wrapping at NUM_REQUESTERS-1 to 0.
  - Register the winner's addr/we/wdata into address_o/write_o/data_o.
  - Set grant_o, set data_valid_o=1, clear the timeout counter, and go to BUSY.
- BUSY:
  - data_valid_o, address_o, write_o and data_o are held stable.
  - data_valid_i=1: capture data_i into rdata_o (reads only; writes leave rdata_o unchanged), drop data_valid_o, and go to DONE.
  - Otherwise the counter increments. On reaching TIMEOUT_CYCLES (when nonzero), drop data_valid_o, leave rdata_o unchanged (open-bus value), set the timeout flag, and go to DONE.
  - data_valid_i in the same cycle the counter reaches TIMEOUT_CYCLES counts as a normal completion.
- DONE:
  - ack_o = grant_o for one cycle, and timeout_o = flag.
  - last_grant is updated to the winner.
  - Next state is IDLE; no arbitration happens in DONE.
- Requesters are sampled only in IDLE.
  - A master that drops req_i at the edge ending its ack cycle is not re-granted.
  - A master holding req_i competes again in the next IDLE, at lowest priority because round-robin has rotated.
- data_valid_i outside BUSY is ignored.
- Changing addr_i/we_i/wdata_i while a master is granted has no effect; values are latched in IDLE.
- Reset:
  - Asynchronous assertion from any state returns to IDLE. Any in-flight transaction is discarded with no ack.
  - Reset values: ack_o=0, timeout_o=0, grant_o=0, rdata_o=8'h00, address_o=16'h0000, data_o=8'h00, write_o=0, data_valid_o=0, counter=0, last_grant=NUM_REQUESTERS-1 (so master 0 wins first).

## Timing
- Minimum transaction length is 3 cycles: IDLE (request sampled), BUSY with data_valid_i high, DONE (ack).
- Latency from req_i high in IDLE to ack_o is 2 + k cycles, where k = number of BUSY cycles before data_valid_i (k ≥ 0).
- Timeout ack arrives TIMEOUT_CYCLES + 2 cycles after the IDLE sample.
- Maximum back-to-back throughput is one transaction per 3 cycles.
- All outputs are registered; there is no combinational path from req_i/data_i to outputs.
- Counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1 bit.

## Structure
- Package bus_pkg holds:
  - the arb_state_e enum (IDLE, BUSY, DONE);
  - the ADDR_W=16 and DATA_W=8 constants;
  - the RESET_RDATA=8'h00 constant.
- Sub-module rr_pick: combinational round-robin picker with inputs req vector and last_grant index, and outputs one-hot grant and index. It is reused by the future PPU bus arbiter.

## Test plan
- Single cpu read of 16'h0200, memory returns 8'h5A in the first BUSY cycle → ack_o[0] exactly 2 cycles after the request, rdata_o=8'h5A, timeout_o=0.
- req_i=2'b11 held continuously, immediate memory response → grants alternate 0,1,0,1; each ack_o is exactly 3 cycles apart.
- Master 1 writes 8'hC3 to 16'h2004, memory delays 4 cycles → data_valid_o/write_o/address_o/data_o stable for 5 BUSY cycles, ack_o[1] at cycle 6, rdata_o unchanged.
- No memory response with TIMEOUT_CYCLES=15 → ack_o[0] and timeout_o at cycle 17, rdata_o holds its previous value; a second run with data_valid_i on the 15th BUSY cycle → timeout_o=0.
- reset_ni pulsed low mid-BUSY → all outputs return to reset values asynchronously, no ack_o is issued, and the next request is granted to master 0.
- data_valid_i pulsed while in IDLE and DONE → no state change and rdata_o unchanged.
